// File: rtl/spi_fir_controller_if.sv
// Bus bundle between spi_fir_controller (slave view) and the SPI slave,
// coefficient RAM, FIR filter and result path around it (master view).
interface spi_fir_controller_if #(
  parameter int unsigned COEF_ADDR_WIDTH = 6
);
  localparam int unsigned DATA_W = 16;

  logic [DATA_W-1:0]          spiDataIn;
  logic                       spiReceivedIn;
  logic                       spiBusyIn;
  logic [DATA_W-1:0]          spiDataOut;
  logic                       coefWeOut;
  logic [COEF_ADDR_WIDTH-1:0] coefAddrOut;
  logic [DATA_W-1:0]          coefDataOut;
  logic [DATA_W-1:0]          sampleOut;
  logic                       sampleValidOut;
  logic                       sampleReadyIn;
  logic [DATA_W-1:0]          resultIn;
  logic                       resultValidIn;

  modport slave (
    input  spiDataIn, spiReceivedIn, spiBusyIn, sampleReadyIn, resultIn, resultValidIn,
    output spiDataOut, coefWeOut, coefAddrOut, coefDataOut, sampleOut, sampleValidOut
  );

  modport master (
    output spiDataIn, spiReceivedIn, spiBusyIn, sampleReadyIn, resultIn, resultValidIn,
    input  spiDataOut, coefWeOut, coefAddrOut, coefDataOut, sampleOut, sampleValidOut
  );
endinterface

// File: rtl/spi_fir_controller.sv
// SPI command decoder for a FIR block: coefficient writes, sample feed, result FIFO readback.
// Optional ECHO opcode enabled by defining SPI_FIR_CTRL_ECHO_EN.
module spi_fir_controller #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned COEF_ADDR_WIDTH = 6
) (
  input  logic                 clkIn,
  input  logic                 nResetIn,
  spi_fir_controller_if.slave  bus
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [3:0] OP_WCOEF  = 4'h1;
  localparam logic [3:0] OP_WSAMP  = 4'h2;
  localparam logic [3:0] OP_RRES   = 4'h3;
  localparam logic [3:0] OP_STATUS = 4'h4;
  localparam logic [3:0] OP_ECHO   = 4'h7;

`ifdef SPI_FIR_CTRL_ECHO_EN
  typedef enum logic [2:0] {
    IDLE, CMD, WCOEF, WSAMP, RRES, ECHO, IGNORE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, CMD, WCOEF, WSAMP, RRES, IGNORE
  } state_t;
`endif

  state_t state_q, state_d;

  logic                       busy_q;
  logic [DATA_W-1:0]          data_out_q, data_out_d;
  logic                       coef_we_q, coef_we_d;
  logic [COEF_ADDR_WIDTH-1:0] coef_addr_out_q, coef_addr_out_d;
  logic [DATA_W-1:0]          coef_data_q, coef_data_d;
  logic [COEF_ADDR_WIDTH-1:0] coef_addr_q, coef_addr_d;
  logic [DATA_W-1:0]          sample_q, sample_d;
  logic                       sample_valid_q, sample_valid_d;
  logic                       ovr_q, ovr_d, unf_q, unf_d, rovf_q, rovf_d;

  logic [DATA_W-1:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]           count_q;

  logic                       busy_rise, busy_fall;
  logic                       fifo_full, fifo_empty;
  logic                       pop_req, pop, push_ok;
  logic                       set_ovr, set_unf, set_rovf, clr_flags;
  logic [3:0]                 opcode;
  logic [DATA_W-1:0]          status_word;

  assign busy_rise   = bus.spiBusyIn & ~busy_q;
  assign busy_fall   = ~bus.spiBusyIn & busy_q;
  assign opcode      = bus.spiDataIn[15:12];
  assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign status_word = {ovr_q, unf_q, rovf_q, 8'h00, 5'(count_q)};

  // A full FIFO still takes a push when the same cycle pops a word.
  assign push_ok  = bus.resultValidIn & (~fifo_full | pop);
  assign set_rovf = bus.resultValidIn & fifo_full & ~pop;

  // Next-state and register-input decode.
  always_comb begin
    state_d         = state_q;
    data_out_d      = data_out_q;
    coef_we_d       = 1'b0;
    coef_addr_out_d = coef_addr_out_q;
    coef_data_d     = coef_data_q;
    coef_addr_d     = coef_addr_q;
    sample_d        = sample_q;
    sample_valid_d  = sample_valid_q;
    pop_req         = 1'b0;
    pop             = 1'b0;
    set_ovr         = 1'b0;
    set_unf         = 1'b0;
    clr_flags       = 1'b0;

    if (sample_valid_q && bus.sampleReadyIn) begin
      sample_valid_d = 1'b0;
    end

    if (busy_fall) begin
      state_d        = IDLE;
      sample_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          data_out_d = status_word;
          if (busy_rise) state_d = CMD;
        end
        CMD: begin
          if (bus.spiReceivedIn) begin
            case (opcode)
              OP_WCOEF: begin
                coef_addr_d = bus.spiDataIn[COEF_ADDR_WIDTH-1:0];
                state_d     = WCOEF;
              end
              OP_WSAMP: state_d = WSAMP;
              OP_RRES: begin
                pop_req = 1'b1;
                state_d = RRES;
              end
              OP_STATUS: begin
                clr_flags = 1'b1;
                state_d   = IGNORE;
              end
`ifdef SPI_FIR_CTRL_ECHO_EN
              OP_ECHO:  state_d = ECHO;
`else
              OP_ECHO:  state_d = IGNORE;
`endif
              default:  state_d = IGNORE;
            endcase
          end
        end
        WCOEF: begin
          if (bus.spiReceivedIn) begin
            coef_we_d       = 1'b1;
            coef_addr_out_d = coef_addr_q;
            coef_data_d     = bus.spiDataIn;
            coef_addr_d     = coef_addr_q + COEF_ADDR_WIDTH'(1);
          end
        end
        WSAMP: begin
          // A still-pending sample wins; the newcomer is dropped and flagged.
          if (bus.spiReceivedIn) begin
            if (sample_valid_q && !bus.sampleReadyIn) begin
              set_ovr = 1'b1;
            end else begin
              sample_d       = bus.spiDataIn;
              sample_valid_d = 1'b1;
            end
          end
        end
        RRES: begin
          if (bus.spiReceivedIn) pop_req = 1'b1;
        end
`ifdef SPI_FIR_CTRL_ECHO_EN
        ECHO: begin
          if (bus.spiReceivedIn) data_out_d = bus.spiDataIn;
        end
`endif
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end

    if (pop_req) begin
      if (!fifo_empty) begin
        pop        = 1'b1;
        data_out_d = mem[rd_ptr_q];
      end else begin
        data_out_d = '0;
        set_unf    = 1'b1;
      end
    end

    ovr_d  = (ovr_q  & ~clr_flags) | set_ovr;
    unf_d  = (unf_q  & ~clr_flags) | set_unf;
    rovf_d = (rovf_q & ~clr_flags) | set_rovf;
  end

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Busy history resets high so a frame already in flight at release is not seen as a new one.
  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      busy_q          <= 1'b1;
      data_out_q      <= '0;
      coef_we_q       <= 1'b0;
      coef_addr_out_q <= '0;
      coef_data_q     <= '0;
      coef_addr_q     <= '0;
      sample_q        <= '0;
      sample_valid_q  <= 1'b0;
      ovr_q           <= 1'b0;
      unf_q           <= 1'b0;
      rovf_q          <= 1'b0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      busy_q          <= bus.spiBusyIn;
      data_out_q      <= data_out_d;
      coef_we_q       <= coef_we_d;
      coef_addr_out_q <= coef_addr_out_d;
      coef_data_q     <= coef_data_d;
      coef_addr_q     <= coef_addr_d;
      sample_q        <= sample_d;
      sample_valid_q  <= sample_valid_d;
      ovr_q           <= ovr_d;
      unf_q           <= unf_d;
      rovf_q          <= rovf_d;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clkIn) begin
    if (push_ok) mem[wr_ptr_q] <= bus.resultIn;
  end

  assign bus.spiDataOut     = data_out_q;
  assign bus.coefWeOut      = coef_we_q;
  assign bus.coefAddrOut    = coef_addr_out_q;
  assign bus.coefDataOut    = coef_data_q;
  assign bus.sampleOut      = sample_q;
  assign bus.sampleValidOut = sample_valid_q;
endmodule

// File: tb/tb_spi_fir_controller.sv
// Directed-plus-random bench for spi_fir_controller against a queue/flag model of the command rules.
module tb_spi_fir_controller;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CAW   = 6;

  logic clk = 1'b0;
  logic nrst;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] mq [$];
  bit          m_ovr, m_unf, m_rovf;
  logic [15:0] v, w, hold, s1, r1, r2;
  int          a, hi;

  always #5 clk = ~clk;

  spi_fir_controller_if #(.COEF_ADDR_WIDTH(CAW)) bus ();

  spi_fir_controller #(.FIFO_DEPTH(DEPTH), .COEF_ADDR_WIDTH(CAW)) dut (
    .clkIn   (clk),
    .nResetIn(nrst),
    .bus     (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_pkt(input logic [15:0] d);
    bus.spiDataIn     = d;
    bus.spiReceivedIn = 1'b1;
    tick();
    bus.spiReceivedIn = 1'b0;
  endtask

  task automatic frame_begin();
    bus.spiBusyIn = 1'b1;
    tick();
  endtask

  task automatic frame_end();
    bus.spiBusyIn = 1'b0;
    tick();
    tick();
  endtask

  function automatic void m_push(input logic [15:0] d);
    if (mq.size() >= DEPTH) m_rovf = 1'b1;
    else                    mq.push_back(d);
  endfunction

  function automatic logic [15:0] m_pop();
    if (mq.size() == 0) begin
      m_unf = 1'b1;
      return 16'h0000;
    end
    return mq.pop_front();
  endfunction

  function automatic logic [15:0] m_status();
    return {m_ovr, m_unf, m_rovf, 8'h00, 5'(mq.size())};
  endfunction

  task automatic push_result(input logic [15:0] d);
    bus.resultIn      = d;
    bus.resultValidIn = 1'b1;
    tick();
    bus.resultValidIn = 1'b0;
    m_push(d);
  endtask

  task automatic clear_flags();
    frame_begin();
    send_pkt(16'h4000);
    frame_end();
    m_ovr = 1'b0; m_unf = 1'b0; m_rovf = 1'b0;
  endtask

  initial begin
    bus.spiDataIn = '0; bus.spiReceivedIn = 1'b0; bus.spiBusyIn = 1'b0;
    bus.sampleReadyIn = 1'b0; bus.resultIn = '0; bus.resultValidIn = 1'b0;
    m_ovr = 1'b0; m_unf = 1'b0; m_rovf = 1'b0;
    nrst = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_spiDataOut", 32'(bus.spiDataOut), 32'h0);
    chk("rst_coefWe",     32'(bus.coefWeOut), 32'h0);
    chk("rst_coefAddr",   32'(bus.coefAddrOut), 32'h0);
    chk("rst_coefData",   32'(bus.coefDataOut), 32'h0);
    chk("rst_sample",     32'(bus.sampleOut), 32'h0);
    chk("rst_sampleVal",  32'(bus.sampleValidOut), 32'h0);
    nrst = 1'b1;
    repeat (2) tick();
    chk("idle_status", 32'(bus.spiDataOut), 32'(m_status()));

    // 64-word coefficient run from address 5, wrapping through 63 -> 0
    frame_begin();
    send_pkt(16'h1005);
    for (int i = 0; i < 64; i++) begin
      w = 16'($urandom);
      send_pkt(w);
      chk("wcoef_we",   32'(bus.coefWeOut), 32'h1);
      chk("wcoef_addr", 32'(bus.coefAddrOut), 32'((5 + i) % 64));
      chk("wcoef_data", 32'(bus.coefDataOut), 32'(w));
      tick();
      chk("wcoef_we_pulse", 32'(bus.coefWeOut), 32'h0);
    end
    frame_end();
    chk("wcoef_status", 32'(bus.spiDataOut), 32'(m_status()));

    // Random start address; high argument bits must be ignored
    a  = int'($urandom_range(0, 63));
    hi = int'($urandom_range(0, 63));
    frame_begin();
    send_pkt({4'h1, 6'(hi), 6'(a)});
    for (int i = 0; i < 3; i++) begin
      w = 16'($urandom);
      send_pkt(w);
      chk("wcoef2_addr", 32'(bus.coefAddrOut), 32'((a + i) % 64));
      chk("wcoef2_data", 32'(bus.coefDataOut), 32'(w));
    end
    frame_end();

    // Sample overrun: second packet dropped, OVR set, pending sample discarded at frame end
    s1 = 16'($urandom);
    frame_begin();
    send_pkt(16'h2000);
    send_pkt(s1);
    chk("samp_valid", 32'(bus.sampleValidOut), 32'h1);
    chk("samp_data",  32'(bus.sampleOut), 32'(s1));
    tick();
    send_pkt(16'($urandom));
    m_ovr = 1'b1;
    chk("samp_keep",  32'(bus.sampleOut), 32'(s1));
    chk("samp_valid2", 32'(bus.sampleValidOut), 32'h1);
    frame_end();
    chk("samp_drop_at_end", 32'(bus.sampleValidOut), 32'h0);
    chk("ovr_status", 32'(bus.spiDataOut), 32'(m_status()));
    chk("ovr_bit15",  32'(bus.spiDataOut[15]), 32'h1);

    // Handshake acceptance, and a packet landing the same cycle the pending one is accepted
    frame_begin();
    send_pkt(16'h2000);
    w = 16'($urandom);
    send_pkt(w);
    bus.sampleReadyIn = 1'b1;
    tick();
    chk("samp_accept", 32'(bus.sampleValidOut), 32'h0);
    bus.sampleReadyIn = 1'b0;
    send_pkt(16'($urandom));
    w = 16'($urandom);
    bus.sampleReadyIn = 1'b1;
    send_pkt(w);
    chk("samp_replace_data",  32'(bus.sampleOut), 32'(w));
    chk("samp_replace_valid", 32'(bus.sampleValidOut), 32'h1);
    tick();
    chk("samp_accept2", 32'(bus.sampleValidOut), 32'h0);
    bus.sampleReadyIn = 1'b0;
    frame_end();
    chk("no_new_ovr", 32'(bus.spiDataOut), 32'(m_status()));

    clear_flags();
    chk("clear_status", 32'(bus.spiDataOut), 32'(m_status()));

    // Result readback with underflow
    push_result(16'h0011);
    push_result(16'h0022);
    tick();
    chk("fifo2_status", 32'(bus.spiDataOut), 32'(m_status()));
    frame_begin();
    send_pkt(16'h3000);
    chk("rres_0", 32'(bus.spiDataOut), 32'(m_pop()));
    for (int i = 1; i < 4; i++) begin
      send_pkt(16'($urandom));
      chk("rres_n", 32'(bus.spiDataOut), 32'(m_pop()));
    end
    frame_end();
    chk("unf_status", 32'(bus.spiDataOut), 32'(m_status()));

    // Overflow on a 5th push, then STATUS clears the flags
    clear_flags();
    for (int i = 0; i < 5; i++) push_result(16'($urandom));
    tick();
    chk("rovf_status", 32'(bus.spiDataOut), 32'(m_status()));
    chk("rovf_const",  32'(bus.spiDataOut), 32'h2004);
    clear_flags();
    chk("rovf_cleared", 32'(bus.spiDataOut), 32'(m_status()));

    // STATUS decode coinciding with a full-FIFO push: ROVF stays set
    frame_begin();
    r1 = 16'($urandom);
    bus.resultIn = r1;
    bus.resultValidIn = 1'b1;
    send_pkt(16'h4000);
    bus.resultValidIn = 1'b0;
    m_ovr = 1'b0; m_unf = 1'b0; m_rovf = 1'b0;
    m_push(r1);
    frame_end();
    chk("clr_vs_set", 32'(bus.spiDataOut), 32'(m_status()));

    // Push and pop together while full is accepted without ROVF
    clear_flags();
    frame_begin();
    send_pkt(16'h3000);
    chk("rres_full_0", 32'(bus.spiDataOut), 32'(m_pop()));
    r1 = 16'($urandom);
    push_result(r1);
    r2 = 16'($urandom);
    bus.resultIn = r2;
    bus.resultValidIn = 1'b1;
    send_pkt(16'($urandom));
    bus.resultValidIn = 1'b0;
    v = m_pop();
    m_push(r2);
    chk("rres_pushpop", 32'(bus.spiDataOut), 32'(v));
    for (int i = 0; i < 5; i++) begin
      send_pkt(16'($urandom));
      chk("rres_drain", 32'(bus.spiDataOut), 32'(m_pop()));
    end
    frame_end();
    chk("pushpop_status", 32'(bus.spiDataOut), 32'(m_status()));

    // Opcode 0x7
    frame_begin();
    hold = m_status();
    send_pkt(16'h7000);
    send_pkt(16'hBEEF);
`ifdef SPI_FIR_CTRL_ECHO_EN
    chk("echo_1", 32'(bus.spiDataOut), 32'h0000BEEF);
`else
    chk("echo_1", 32'(bus.spiDataOut), 32'(hold));
`endif
    send_pkt(16'hCAFE);
`ifdef SPI_FIR_CTRL_ECHO_EN
    chk("echo_2", 32'(bus.spiDataOut), 32'h0000CAFE);
`else
    chk("echo_2", 32'(bus.spiDataOut), 32'(hold));
`endif
    frame_end();

    // spiBusyIn rising together with spiReceivedIn: that packet is not a command
    bus.spiBusyIn = 1'b1;
    send_pkt(16'h1005);
    chk("rise_rx_no_we", 32'(bus.coefWeOut), 32'h0);
    send_pkt(16'h1010);
    w = 16'($urandom);
    send_pkt(w);
    chk("rise_rx_we",   32'(bus.coefWeOut), 32'h1);
    chk("rise_rx_addr", 32'(bus.coefAddrOut), 32'h10);
    tick();
    // Frame end beats a packet in the same cycle
    bus.spiBusyIn = 1'b0;
    send_pkt(16'($urandom));
    chk("fall_prio_no_we", 32'(bus.coefWeOut), 32'h0);
    tick();

    // Reset mid-WCOEF aborts the frame
    frame_begin();
    send_pkt(16'h1020);
    send_pkt(16'($urandom));
    chk("pre_rst_we", 32'(bus.coefWeOut), 32'h1);
    nrst = 1'b0;
    #1;
    mq.delete();
    m_ovr = 1'b0; m_unf = 1'b0; m_rovf = 1'b0;
    chk("mid_rst_we",     32'(bus.coefWeOut), 32'h0);
    chk("mid_rst_addr",   32'(bus.coefAddrOut), 32'h0);
    chk("mid_rst_data",   32'(bus.coefDataOut), 32'h0);
    chk("mid_rst_spiout", 32'(bus.spiDataOut), 32'h0);
    chk("mid_rst_sample", 32'(bus.sampleOut), 32'h0);
    tick();
    nrst = 1'b1;
    tick();
    send_pkt(16'($urandom));
    chk("post_rst_no_we", 32'(bus.coefWeOut), 32'h0);
    tick();
    chk("post_rst_status", 32'(bus.spiDataOut), 32'(m_status()));
    frame_end();
    frame_begin();
    send_pkt(16'h1003);
    w = 16'($urandom);
    send_pkt(w);
    chk("new_frame_we",   32'(bus.coefWeOut), 32'h1);
    chk("new_frame_addr", 32'(bus.coefAddrOut), 32'h3);
    chk("new_frame_data", 32'(bus.coefDataOut), 32'(w));
    frame_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
